// File: rtl/cdb_arbiter.sv
// Arbitrates NUM_REQ execute-side results onto NUM_CDB common-data-bus ports.
// Grants are round-robin, with a starvation override; granted results are registered for one cycle.

module cdb_wait_cnt #(
  parameter int LIMIT = 3,
  parameter int W     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starved
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                               cnt_d = '0;
    else if (inc && cnt_q != W'(LIMIT))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign starved = (cnt_q == W'(LIMIT));
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CDB      = 2,
  parameter int XLEN         = 32,
  parameter int PRF_IDX_W    = 6,
  parameter int ROB_IDX_W    = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_reg_write,
  input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_prf_idx,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*XLEN-1:0]        req_value,
  output logic [NUM_REQ-1:0]             hazard,
  output logic [NUM_CDB-1:0]             cdb_valid,
  output logic [NUM_CDB-1:0]             cdb_reg_write,
  output logic [NUM_CDB*PRF_IDX_W-1:0]   cdb_prf_idx,
  output logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx,
  output logic [NUM_CDB*XLEN-1:0]        cdb_value
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0]                 rr_q, rr_d;
  logic [NUM_REQ-1:0]               gnt, starved;
  logic [NUM_CDB-1:0]               port_used;
  logic [NUM_CDB-1:0][PTR_W-1:0]    port_src;

  // Starved requesters are placed first, then the round-robin scan fills remaining ports.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last_src;
    int               n;
    gnt       = '0;
    port_used = '0;
    port_src  = '0;
    last_src  = rr_q;
    idx       = '0;
    n         = 0;
    if (!reset && !flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && starved[i] && n < NUM_CDB) begin
          gnt[i]       = 1'b1;
          port_used[n] = 1'b1;
          port_src[n]  = PTR_W'(i);
          last_src     = PTR_W'(i);
          n            = n + 1;
        end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = PTR_W'((int'(rr_q) + j) % NUM_REQ);
        if (req_valid[idx] && !gnt[idx] && n < NUM_CDB) begin
          gnt[idx]     = 1'b1;
          port_used[n] = 1'b1;
          port_src[n]  = idx;
          last_src     = idx;
          n            = n + 1;
        end
      end
    end
    rr_d = (n > 0) ? PTR_W'((int'(last_src) + 1) % NUM_REQ) : rr_q;
  end

  assign hazard = req_valid & ~gnt;

  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    cdb_wait_cnt #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_wait (
      .clock   (clock),
      .reset   (reset),
      .clr     (flush | ~req_valid[i] | gnt[i]),
      .inc     (hazard[i]),
      .starved (starved[i])
    );
  end

  // Unused ports drop valid but keep their last payload.
  for (genvar k = 0; k < NUM_CDB; k++) begin : g_port
    always_ff @(posedge clock) begin
      if (reset) begin
        cdb_valid[k]                               <= 1'b0;
        cdb_reg_write[k]                           <= 1'b0;
        cdb_prf_idx[k*PRF_IDX_W +: PRF_IDX_W]      <= '0;
        cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W]      <= '0;
        cdb_value[k*XLEN +: XLEN]                  <= '0;
      end else begin
        cdb_valid[k] <= port_used[k];
        if (port_used[k]) begin
          cdb_reg_write[k]                         <= req_reg_write[port_src[k]];
          cdb_prf_idx[k*PRF_IDX_W +: PRF_IDX_W]    <= req_prf_idx[port_src[k]*PRF_IDX_W +: PRF_IDX_W];
          cdb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W]    <= req_rob_idx[port_src[k]*ROB_IDX_W +: ROB_IDX_W];
          cdb_value[k*XLEN +: XLEN]                <= req_value[port_src[k]*XLEN +: XLEN];
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int NR = 4, NC = 2, XL = 32, PW = 6, RW = 5, SL = 3;

  logic clock = 1'b0;
  logic reset = 1'b1, flush = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_reg_write = '0;
  logic [NR*PW-1:0] req_prf_idx = '0;
  logic [NR*RW-1:0] req_rob_idx = '0;
  logic [NR*XL-1:0] req_value = '0;
  logic [NR-1:0]    hazard;
  logic [NC-1:0]    cdb_valid, cdb_reg_write;
  logic [NC*PW-1:0] cdb_prf_idx;
  logic [NC*RW-1:0] cdb_rob_idx;
  logic [NC*XL-1:0] cdb_value;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC), .XLEN(XL), .PRF_IDX_W(PW),
                .ROB_IDX_W(RW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_reg_write(req_reg_write),
    .req_prf_idx(req_prf_idx), .req_rob_idx(req_rob_idx), .req_value(req_value),
    .hazard(hazard), .cdb_valid(cdb_valid), .cdb_reg_write(cdb_reg_write),
    .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
  );

  int tests = 0, fails = 0;

  // Model state: per-requester denial counts, rotation pointer, expected CDB contents.
  int          m_w[NR];
  int          m_rr = 0;
  bit          m_haz[NR];
  bit          m_v[NC], m_rwr[NC];
  int unsigned m_prf[NC], m_rob[NC], m_val[NC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit rw, input int prf,
                         input int rob, input int unsigned val);
    req_valid[i]              = v;
    req_reg_write[i]          = rw;
    req_prf_idx[i*PW +: PW]   = PW'(prf);
    req_rob_idx[i*RW +: RW]   = RW'(rob);
    req_value[i*XL +: XL]     = val;
  endtask

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic step();
    int q[$];
    bit g[NR];
    logic [NR-1:0] eh;
    #1;
    q = {};
    for (int i = 0; i < NR; i++) g[i] = 0;
    if (!reset && !flush) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && m_w[i] == SL && q.size() < NC) begin q.push_back(i); g[i] = 1; end
      for (int j = 0; j < NR; j++) begin
        int idx = (m_rr + j) % NR;
        if (req_valid[idx] && !g[idx] && q.size() < NC) begin q.push_back(idx); g[idx] = 1; end
      end
    end
    for (int i = 0; i < NR; i++) eh[i] = req_valid[i] && !g[i];

    chk("hazard", 64'(hazard), 64'(eh));
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("cdb_valid[%0d]", k), 64'(cdb_valid[k]), 64'(m_v[k]));
      chk($sformatf("cdb_reg_write[%0d]", k), 64'(cdb_reg_write[k]), 64'(m_rwr[k]));
      chk($sformatf("cdb_prf_idx[%0d]", k), 64'(cdb_prf_idx[k*PW +: PW]), 64'(m_prf[k]));
      chk($sformatf("cdb_rob_idx[%0d]", k), 64'(cdb_rob_idx[k*RW +: RW]), 64'(m_rob[k]));
      chk($sformatf("cdb_value[%0d]", k), 64'(cdb_value[k*XL +: XL]), 64'(m_val[k]));
    end

    if (reset) begin
      m_rr = 0;
      for (int i = 0; i < NR; i++) m_w[i] = 0;
      for (int k = 0; k < NC; k++) begin
        m_v[k] = 0; m_rwr[k] = 0; m_prf[k] = 0; m_rob[k] = 0; m_val[k] = 0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        m_v[k] = (k < q.size());
        if (m_v[k]) begin
          m_rwr[k] = req_reg_write[q[k]];
          m_prf[k] = req_prf_idx[q[k]*PW +: PW];
          m_rob[k] = req_rob_idx[q[k]*RW +: RW];
          m_val[k] = req_value[q[k]*XL +: XL];
        end
      end
      for (int i = 0; i < NR; i++)
        m_w[i] = (flush || !req_valid[i] || g[i]) ? 0 : ((m_w[i] < SL) ? m_w[i] + 1 : SL);
      if (q.size() > 0) m_rr = (q[q.size()-1] + 1) % NR;
    end
    for (int i = 0; i < NR; i++) m_haz[i] = eh[i];
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int wsum;
    @(negedge clock);
    // Reset, then idle for 10 cycles.
    reset = 1; step(); step();
    reset = 0;
    for (int c = 0; c < 10; c++) begin
      #1 chk("idle_hazard", 64'(hazard), 64'h0);
      chk("idle_cdb_valid", 64'(cdb_valid), 64'h0);
      step();
    end

    // Single request from lane 0.
    set_req(0, 1, 1, 5, 3, 32'h1234);
    #1 chk("single_hazard", 64'(hazard), 64'h0);
    step();
    req_valid = '0;
    #1 chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("single_value", 64'(cdb_value[XL-1:0]), 64'h1234);
    chk("single_prf", 64'(cdb_prf_idx[PW-1:0]), 64'd5);
    chk("single_rob", 64'(cdb_rob_idx[RW-1:0]), 64'd3);
    chk("single_rr", 64'(m_rr), 64'd1);
    step();

    // Re-reset to bring the pointer to 0, then all four request.
    reset = 1; step(); reset = 0;
    for (int i = 0; i < NR; i++) set_req(i, 1, i[0], 10 + i, 20 + i, 32'hA000 + i);
    #1 chk("all_hazard_t", 64'(hazard), 64'hC);
    step();
    set_req(0, 1, 0, 30, 7, 32'hB000);
    set_req(1, 1, 1, 31, 8, 32'hB001);
    #1 chk("all_hazard_t1", 64'(hazard), 64'h3);
    chk("all_port0", 64'(cdb_value[XL-1:0]), 64'hA000);
    chk("all_port1", 64'(cdb_value[2*XL-1:XL]), 64'hA001);
    step();
    chk("all_rr", 64'(m_rr), 64'd0);
    #1 chk("all_port0_t2", 64'(cdb_value[XL-1:0]), 64'hA002);
    chk("all_port1_t2", 64'(cdb_value[2*XL-1:XL]), 64'hA003);

    // Flush with lanes 1,2 requesting.
    req_valid = 4'b0110; flush = 1;
    #1 chk("flush_hazard", 64'(hazard), 64'h6);
    step();
    flush = 0; req_valid = '0;
    #1 chk("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    wsum = 0;
    for (int i = 0; i < NR; i++) wsum += m_w[i];
    chk("flush_wait_sum", 64'(wsum), 64'd0);
    step();

    // Grant, then reset the next cycle: result must not reappear.
    set_req(2, 1, 1, 44, 9, 32'hDEAD);
    step();
    req_valid = '0; reset = 1;
    step();
    reset = 0;
    #1 chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_rr", 64'(m_rr), 64'd0);
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic honouring the hold-on-hazard handshake.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++)
        if (!m_haz[i])
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 63), $urandom_range(0, 31), $urandom);
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0; flush = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
